// File: rtl/data_memory.sv
// ============================================================================
// Module   : data_memory
// Brief    : Word-organised MEM-stage data memory, synchronous write,
//            combinational gated read, asynchronous active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory #(
    parameter int DEPTH    = 1024,
    parameter int ADDR_LSB = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      r_mem [DEPTH];
    logic [IDX_W-1:0] w_idx;
    logic             w_unused_addr;

    // Byte offset and bits above the index are dropped: aligned, wrapping access.
    assign w_idx         = Address[ADDR_LSB +: IDX_W];
    assign w_unused_addr = ^Address;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
        end else if (MemWrite == 1'b1) begin
            r_mem[w_idx] <= WriteData;
        end
    end

    // An unknown MemRead falls to the else branch so ReadData stays 0, not X.
    always_comb begin
        ReadData = 32'h0000_0000;
        if (MemRead == 1'b1) begin
            ReadData = r_mem[w_idx];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_memory.sv
// ============================================================================
// Module   : tb_data_memory
// Brief    : Directed self-checking bench for data_memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory;

    logic        Clk;
    logic        Rst;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;

    int n_checks = 0;
    int n_fail   = 0;

    data_memory #(
        .DEPTH    (1024),
        .ADDR_LSB (2)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] expected);
        n_checks++;
        assert (ReadData === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, ReadData, expected);
        end
    endtask

    // Set up a write at a falling edge, let one rising edge capture it.
    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        @(negedge Clk);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        @(posedge Clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    task automatic read_at(input logic [31:0] addr);
        @(negedge Clk);
        Address = addr;
        MemRead = 1'b1;
        #1;
    endtask

    initial begin
        // Enable sequencing from X; rising edges at 5, 15, ..., 95, 105, ...
        Rst       = 1'b0;
        Address   = 32'h0000_0008;
        WriteData = 32'h0000_00FF;
        #22 Rst = 1'b1;
        #8;                                   // t = 30
        check("x_enables_read_zero", 32'h0);
        #20 MemRead = 1'b1;                   // t = 50
        #2  check("read_before_write", 32'h0);
        #48 MemWrite = 1'b1;                  // t = 100
        #2  check("enable_before_edge", 32'h0);
        #5  check("enable_after_edge", 32'h0000_00FF);  // t = 107
        #43 MemWrite = 1'b0;                  // t = 150
        #2  WriteData = 32'h0000_0001;
        #5  check("no_write_after_disable", 32'h0000_00FF); // t = 157
        #43 MemRead = 1'b0;                   // t = 200
        #2  check("read_disabled_zero", 32'h0);

        // Basic write/read
        write_word(32'h0000_0010, 32'hDEAD_BEEF);
        read_at(32'h0000_0010);
        check("write_read_0x10", 32'hDEAD_BEEF);
        MemRead = 1'b0;
        #1 check("read_gate_off", 32'h0);

        // Alignment and wrap
        write_word(32'h0000_0020, 32'h1234_5678);
        read_at(32'h0000_0023);
        check("misaligned_0x23", 32'h1234_5678);
        read_at(32'h0000_1020);
        check("wrap_0x1020", 32'h1234_5678);
        read_at(32'h0000_0024);
        check("neighbour_0x24", 32'h0);

        // Simultaneous read and write
        write_word(32'h0000_0040, 32'hAAAA_0000);
        @(negedge Clk);
        Address   = 32'h0000_0040;
        MemRead   = 1'b1;
        WriteData = 32'h5555_FFFF;
        MemWrite  = 1'b1;
        #1 check("rw_before_edge", 32'hAAAA_0000);
        @(posedge Clk);
        #1 check("rw_after_edge", 32'h5555_FFFF);
        MemWrite = 1'b0;

        // Back-to-back writes, last one wins
        @(negedge Clk);
        Address   = 32'h0000_0044;
        WriteData = 32'h0000_0011;
        MemWrite  = 1'b1;
        @(negedge Clk);
        WriteData = 32'h0000_0022;
        @(negedge Clk);
        MemWrite  = 1'b0;
        #1 check("back_to_back_last_wins", 32'h0000_0022);

        // Reset mid-run
        write_word(32'h0000_0100, 32'hCAFE_F00D);
        read_at(32'h0000_0100);
        check("pre_reset_0x100", 32'hCAFE_F00D);
        #1 Rst = 1'b0;
        #1 check("async_clear_0x100", 32'h0);
        WriteData = 32'h0000_0077;
        MemWrite  = 1'b1;
        @(posedge Clk);
        #1 check("write_in_reset_ignored", 32'h0);
        MemWrite = 1'b0;
        @(negedge Clk);
        #1 Rst = 1'b1;
        #1 check("post_reset_0x100", 32'h0);
        read_at(32'h0000_0010);
        check("post_reset_0x10", 32'h0);
        read_at(32'h0000_0000);
        check("reset_addr_0", 32'h0);
        read_at(32'h0000_0004);
        check("reset_addr_4", 32'h0);
        read_at(32'h0000_0FFC);
        check("reset_addr_ffc", 32'h0);

        // Writes resume after reset release
        write_word(32'h0000_0FFC, 32'h0000_0099);
        #1 check("write_after_reset_ffc", 32'h0000_0099);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
